program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Upstream instruction/data source for the processor. A host streams program words in
//   byte-serial form into an internal DEPTH-word store. In RUN the block serves the word at
//   the processor's pc_addr on data_in and qualifies it with data_valid.
//   Outputs connect directly to the processor's data_in, data_valid and pc_addr ports.
// PARAMETERS
//   WORD_W  16  program word width; must be 16, as two host bytes make one word
//   DEPTH   8   number of program words
//   ADDR_W  3   pc_addr width; DEPTH == 2**ADDR_W
// PORTS
//   clk              input   1       system clock, rising edge
//   rst              input   1       asynchronous, active-high reset
//   host_start       input   1       pulse: begin or restart a program load
//   host_end         input   1       pulse: terminate the load early
//   host_byte        input   8       load byte; low byte of each word first
//   host_byte_valid  input   1       host_byte is valid this cycle
//   host_ready       output  1       block accepts host bytes (LOAD_LO/LOAD_HI)
//   pc_addr          input   ADDR_W  word address from the processor
//   data_in          output  WORD_W  registered program word for the processor
//   data_valid       output  1       data_in holds a loaded word for the current pc_addr
//   loaded           output  1       high while in RUN
//   load_err         output  1       sticky: load ended with a half-written word
// BEHAVIOUR
//   Reset (async): state=IDLE, wr_ptr=0, lo_byte=0, pc_q=0, all entry-valid bits vld[]=0.
//     Outputs: data_in=0, data_valid=0, loaded=0, load_err=0, host_ready=0.
//     Store contents are don't-care, because every read is gated by vld[].
//   States: IDLE, LOAD_LO, LOAD_HI, RUN.
//   host_ready = (state==LOAD_LO || state==LOAD_HI); a byte is taken when host_byte_valid && host_ready.
//   host_start in any state (highest priority):
//     clear vld[], wr_ptr=0, load_err=0; go to LOAD_LO.
//     Any byte or end in the same cycle is dropped.
//   LOAD_LO:
//     host_end: go to RUN with no error; a same-cycle byte is dropped.
//     Else on a byte: lo_byte <= host_byte; go to LOAD_HI.
//   LOAD_HI, on a byte:
//     mem[wr_ptr] <= {host_byte, lo_byte}; vld[wr_ptr] <= 1.
//     If wr_ptr==DEPTH-1, go to RUN (no wrap). Else wr_ptr++ and go to LOAD_LO.
//   LOAD_HI, host_end with no byte: load_err <= 1, the partial word is discarded, go to RUN.
//   LOAD_HI, host_end together with a byte: the word is written first, then go to RUN; load_err stays 0.
//   IDLE: ignores bytes and host_end.
//   loaded is registered and equals 1 in the cycle after the RUN transition edge.
//   Read path, every clock edge:
//     pc_q <= pc_addr.
//     data_valid <= (state==RUN) && vld[pc_addr] && (pc_addr==pc_q).
//     data_in <= vld[pc_addr] ? mem[pc_addr] : 0.
//   Latency: once pc_addr changes, data_valid is low for one cycle. It rises on the second edge
//     after the change, provided pc_addr holds. data_in is updated after one edge.
//   Leaving RUN: data_valid falls on the edge that leaves RUN and stays 0 outside RUN.
//   Unwritten entries: data_in=0 and data_valid=0 at every pc_addr.
//   Reload: a reload clears vld[], so stale words are never served as valid.
//   Reset mid-load or mid-RUN returns everything to the reset values.
// TESTING
//   T1 Reset asserted asynchronously mid-cycle -> data_in=0, data_valid=0, host_ready=0,
//      loaded=0 and load_err=0 immediately.
//   T2 host_start, then 16 bytes loading words 0x1000..0x1007 (0x00,0x10,0x01,0x10,...) ->
//      loaded=1 after the last byte. With pc_addr=3 held: data_in=0x1003 and data_valid=1
//      on the second edge.
//   T3 In RUN, pc_addr 3->4 -> data_valid=0 for exactly one cycle, then data_in=0x1004 and data_valid=1.
//   T4 Load 3 words then pulse host_end in LOAD_LO ->
//      pc_addr=5: data_in=0, data_valid=0.
//      pc_addr=2: the third word, valid. load_err=0.
//   T5 Load 1 word, send low byte 0xAB, then host_end ->
//      load_err=1 and pc_addr=1 not valid.
//      A following host_start clears load_err.
//   T6 Edge cases:
//      - host_start during RUN -> data_valid=0 and loaded=0 from the next cycle.
//      - host_start together with host_byte_valid -> the byte is dropped (wr_ptr stays 0).
//      - rst asserted in LOAD_HI -> IDLE with all vld[] cleared.

Source files
------------

// File: rtl/program_loader.sv
// Byte-serial program loader: host fills a word store, RUN serves
// words to the processor at pc_addr with a stable-address qualifier.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   host_start/host_end       start (or restart) / early-end pulses
//   host_byte/host_byte_valid byte stream, low byte of each word first
//   host_ready                bytes accepted (LOAD_LO/LOAD_HI)
//   pc_addr                   processor word address
//   data_in/data_valid        registered word and its qualifier
//   loaded                    high while in RUN
//   load_err                  sticky: load ended on a half word
module program_loader #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_start,
  input  logic              host_end,
  input  logic [7:0]        host_byte,
  input  logic              host_byte_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [WORD_W-1:0] data_in,
  output logic              data_valid,
  output logic              loaded,
  output logic              load_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    RUN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        lo_byte;
  logic [ADDR_W-1:0] pc_q;
  logic [DEPTH-1:0]  vld;
  logic [WORD_W-1:0] mem [DEPTH];

  logic take;
  logic lo_en;
  logic wr_en;
  logic ptr_inc;
  logic err_set;
  logic last;

  assign host_ready = (state == LOAD_LO) || (state == LOAD_HI);
  assign take       = host_byte_valid && host_ready;
  assign last       = (wr_ptr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // host_start overrides everything, including a same-cycle
  // byte or end pulse.
  always_comb begin
    state_n = state;
    lo_en   = 1'b0;
    wr_en   = 1'b0;
    ptr_inc = 1'b0;
    err_set = 1'b0;
    if (host_start) begin
      state_n = LOAD_LO;
    end else begin
      unique case (state)
        IDLE: ;
        LOAD_LO: begin
          if (host_end) begin
            state_n = RUN;
          end else if (take) begin
            lo_en   = 1'b1;
            state_n = LOAD_HI;
          end
        end
        LOAD_HI: begin
          if (take) begin
            wr_en = 1'b1;
            if (host_end || last) begin
              state_n = RUN;
            end else begin
              ptr_inc = 1'b1;
              state_n = LOAD_LO;
            end
          end else if (host_end) begin
            err_set = 1'b1;
            state_n = RUN;
          end
        end
        RUN: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      lo_byte  <= '0;
      vld      <= '0;
      load_err <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      loaded <= (state_n == RUN);
      if (host_start) begin
        wr_ptr   <= '0;
        vld      <= '0;
        load_err <= 1'b0;
      end else begin
        if (lo_en)   lo_byte     <= host_byte;
        if (wr_en)   vld[wr_ptr] <= 1'b1;
        if (ptr_inc) wr_ptr      <= wr_ptr + 1'b1;
        if (err_set) load_err    <= 1'b1;
      end
    end
  end

  // Store needs no reset: every read is gated by vld.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {host_byte, lo_byte};
  end

  // Qualifier uses state_n as well so it drops on the edge
  // that leaves RUN rather than one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      data_valid <= 1'b0;
      data_in    <= '0;
    end else begin
      pc_q       <= pc_addr;
      data_valid <= (state == RUN) && (state_n == RUN)
                    && vld[pc_addr] && (pc_addr == pc_q);
      data_in    <= vld[pc_addr] ? mem[pc_addr] : '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_start;
  logic        host_end;
  logic [7:0]  host_byte;
  logic        host_byte_valid;
  logic        host_ready;
  logic [2:0]  pc_addr;
  logic [15:0] data_in;
  logic        data_valid;
  logic        loaded;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk             (clk),
    .rst             (rst),
    .host_start      (host_start),
    .host_end        (host_end),
    .host_byte       (host_byte),
    .host_byte_valid (host_byte_valid),
    .host_ready      (host_ready),
    .pc_addr         (pc_addr),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .loaded          (loaded),
    .load_err        (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    host_byte       = b;
    host_byte_valid = 1'b1;
    tick();
    host_byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic pulse_end();
    host_end = 1'b1;
    tick();
    host_end = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    host_start      = 1'b0;
    host_end        = 1'b0;
    host_byte       = 8'h00;
    host_byte_valid = 1'b0;
    pc_addr         = 3'd0;
    repeat (2) tick();
    checks++;
    if ({data_in, data_valid, loaded, load_err, host_ready} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {data_in, data_valid, loaded, load_err, host_ready});
    end
    release_rst();
    send_byte(8'h42);
    checks++;
    if (host_ready !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores got rdy=%b ld=%b want 0 0",
               host_ready, loaded);
    end
  endtask

  task automatic test_full_load();
    pulse_start();
    checks++;
    if (host_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready got %b want 1", host_ready);
    end
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i));
      send_byte(8'h10);
    end
    checks++;
    if (loaded !== 1'b1 || host_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_loaded got ld=%b rdy=%b want 1 0",
               loaded, host_ready);
    end
    pc_addr = 3'd3;
    tick();
    checks++;
    if (data_in !== 16'h1003 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL pc3_edge1 got %h/%b want 1003/0",
               data_in, data_valid);
    end
    tick();
    checks++;
    if (data_in !== 16'h1003 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc3_edge2 got %h/%b want 1003/1",
               data_in, data_valid);
    end
  endtask

  task automatic test_addr_change();
    pc_addr = 3'd4;
    tick();
    checks++;
    if (data_in !== 16'h1004 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL pc4_edge1 got %h/%b want 1004/0",
               data_in, data_valid);
    end
    tick();
    checks++;
    if (data_in !== 16'h1004 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc4_edge2 got %h/%b want 1004/1",
               data_in, data_valid);
    end
    pc_addr = 3'd7;
    tick();
    tick();
    checks++;
    if (data_in !== 16'h1007 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc7_last got %h/%b want 1007/1",
               data_in, data_valid);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({data_in, data_valid, loaded, load_err, host_ready} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {data_in, data_valid, loaded, load_err, host_ready});
    end
    release_rst();
    pc_addr = 3'd0;
  endtask

  task automatic test_early_end();
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h33);
    pulse_end();
    checks++;
    if (loaded !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL early_end got ld=%b err=%b want 1 0",
               loaded, load_err);
    end
    pc_addr = 3'd5;
    tick();
    tick();
    checks++;
    if (data_in !== 16'h0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL unwritten5 got %h/%b want 0000/0",
               data_in, data_valid);
    end
    pc_addr = 3'd2;
    tick();
    tick();
    checks++;
    if (data_in !== 16'h3333 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL word2 got %h/%b want 3333/1",
               data_in, data_valid);
    end
  endtask

  task automatic test_half_word();
    pulse_start();
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hAB);
    pulse_end();
    checks++;
    if (load_err !== 1'b1 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL half_err got err=%b ld=%b want 1 1",
               load_err, loaded);
    end
    pc_addr = 3'd1;
    tick();
    tick();
    checks++;
    if (data_in !== 16'h0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL half_pc1 got %h/%b want 0000/0",
               data_in, data_valid);
    end
    pc_addr = 3'd0;
    tick();
    tick();
    checks++;
    if (data_in !== 16'h1234 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL half_pc0 got %h/%b want 1234/1",
               data_in, data_valid);
    end
    pulse_start();
    checks++;
    if (load_err !== 1'b0 || host_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got err=%b rdy=%b want 0 1",
               load_err, host_ready);
    end
  endtask

  task automatic test_edge_cases();
    send_byte(8'hEF);
    send_byte(8'hBE);
    pulse_end();
    pc_addr = 3'd0;
    tick();
    tick();
    checks++;
    if (data_in !== 16'hBEEF || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_word got %h/%b want beef/1",
               data_in, data_valid);
    end
    host_start      = 1'b1;
    host_byte       = 8'h55;
    host_byte_valid = 1'b1;
    tick();
    host_start      = 1'b0;
    host_byte_valid = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || loaded !== 1'b0 || host_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_run got dv=%b ld=%b rdy=%b want 0 0 1",
               data_valid, loaded, host_ready);
    end
    send_byte(8'h22);
    send_byte(8'h11);
    pulse_end();
    tick();
    tick();
    checks++;
    if (data_in !== 16'h1122 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_drop got %h/%b want 1122/1",
               data_in, data_valid);
    end
    pc_addr = 3'd1;
    tick();
    tick();
    checks++;
    if (data_in !== 16'h0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reload_stale got %h/%b want 0000/0",
               data_in, data_valid);
    end
    pulse_start();
    send_byte(8'h77);
    checks++;
    if (host_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_load_hi got rdy=%b want 1", host_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (host_ready !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_hi got rdy=%b ld=%b want 0 0",
               host_ready, loaded);
    end
    release_rst();
    send_byte(8'h88);
    pulse_end();
    checks++;
    if (host_ready !== 1'b0 || loaded !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle got rdy=%b ld=%b dv=%b want 0 0 0",
               host_ready, loaded, data_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_addr_change();
    test_async_reset();
    test_early_end();
    test_half_word();
    test_edge_cases();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
